// File: rtl/fir_pkg.sv
// Shared widths, decimation codes and saturation limits for the FIR output stage.
package fir_pkg;

  localparam int IN_W  = 16;
  localparam int ACC_W = 19;
  localparam int OUT_W = 8;

  localparam logic [1:0] DECIM_1 = 2'b00;
  localparam logic [1:0] DECIM_2 = 2'b01;
  localparam logic [1:0] DECIM_4 = 2'b10;
  localparam logic [1:0] DECIM_8 = 2'b11;

  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  // Phase value on which the accumulator dumps (N-1).
  function automatic logic [2:0] phase_last(input logic [1:0] decim);
    logic [2:0] last;
    case (decim)
      DECIM_1: last = 3'd0;
      DECIM_2: last = 3'd1;
      DECIM_4: last = 3'd3;
      DECIM_8: last = 3'd7;
      default: last = 3'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO; head is presented combinationally, 0 when empty.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted only when paired with a pop.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fir_decim_out.sv
// Accumulate-and-dump decimator with arithmetic shift and 8-bit saturation,
// feeding a show-ahead FIFO with level and sticky overflow status.
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int IN_W  = fir_pkg::IN_W,
  parameter int ACC_W = fir_pkg::ACC_W,
  parameter int OUT_W = fir_pkg::OUT_W,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      cfg_load,
  input  logic [1:0]                cfg_decim,
  input  logic [3:0]                cfg_shift,
  input  logic                      out_rd,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_valid,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow,
  input  logic                      clr_ovf
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(OUT_MIN);

  logic [1:0]              decim_r;
  logic [3:0]              shift_r;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] scaled;
  logic [2:0]              phase;
  logic                    sample_ok;
  logic                    dump;
  logic [OUT_W-1:0]        sat_byte;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    drop;

  // A sample coinciding with cfg_load is discarded along with the partial sum.
  assign sample_ok = in_valid && !cfg_load;
  assign dump      = sample_ok && (phase == phase_last(decim_r));

  assign sum    = acc + {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign scaled = sum >>> shift_r;

  always_comb begin
    sat_byte = scaled[OUT_W-1:0];
    if (scaled > SAT_HI) begin
      sat_byte = SAT_HI[OUT_W-1:0];
    end else if (scaled < SAT_LO) begin
      sat_byte = SAT_LO[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_r <= DECIM_1;
      shift_r <= '0;
    end else if (cfg_load) begin
      decim_r <= cfg_decim;
      shift_r <= cfg_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      phase <= '0;
    end else if (cfg_load) begin
      acc   <= '0;
      phase <= '0;
    end else if (sample_ok) begin
      if (dump) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + 3'd1;
      end
    end
  end

  fir_sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (dump),
    .push_data (sat_byte),
    .pop       (out_rd),
    .rd_data   (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign drop      = dump && fifo_full && !out_rd;

  // Set takes priority so a drop coinciding with a clear is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decim_out.sv
// Directed vector bench for fir_decim_out: table of per-cycle stimulus and
// expected FIFO head/valid/level/overflow, plus an async reset sequence.
module tb_fir_decim_out;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        cfg_load = 1'b0;
  logic [1:0]  cfg_decim = '0;
  logic [3:0]  cfg_shift = '0;
  logic        out_rd = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_decim_out dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .cfg_load   (cfg_load),
    .cfg_decim  (cfg_decim),
    .cfg_shift  (cfg_shift),
    .out_rd     (out_rd),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        cl;
    logic [1:0]  dc;
    logic [3:0]  sh;
    logic        rd;
    logic        co;
    logic        ev;
    logic [7:0]  ed;
    logic [2:0]  el;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int iv, input int id, input int cl, input int dc, input int sh,
                     input int rd, input int co, input int ev, input int ed, input int el,
                     input int eo);
    vec_t v;
    v.iv = 1'(iv); v.id = 16'(id); v.cl = 1'(cl); v.dc = 2'(dc); v.sh = 4'(sh);
    v.rd = 1'(rd); v.co = 1'(co); v.ev = 1'(ev); v.ed = 8'(ed); v.el = 3'(el);
    v.eo = 1'(eo);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic ev, input logic [7:0] ed,
                         input logic [2:0] el, input logic eo);
    chk({tag, ".out_valid"}, idx, int'(out_valid), int'(ev));
    chk({tag, ".out_data"}, idx, int'(out_data), int'(ed));
    chk({tag, ".fifo_level"}, idx, int'(fifo_level), int'(el));
    chk({tag, ".overflow"}, idx, int'(overflow), int'(eo));
  endtask

  task automatic drive(input logic iv, input logic [15:0] id, input logic cl, input logic [1:0] dc,
                       input logic [3:0] sh, input logic rd, input logic co);
    in_valid = iv; in_data = id; cfg_load = cl; cfg_decim = dc; cfg_shift = sh;
    out_rd = rd; clr_ovf = co;
    @(posedge clk);
    #1;
    in_valid = 1'b0; cfg_load = 1'b0; out_rd = 1'b0; clr_ovf = 1'b0;
  endtask

  initial begin
    // Factor 2, shift 1: 10+20 -> 15; 100+200=300 -> 150 -> saturated 127.
    add(0, 0, 1, 1, 1, 0, 0,   0, 0, 0, 0);
    add(1, 10, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(1, 20, 0, 0, 0, 0, 0,  1, 15, 1, 0);
    add(1, 100, 0, 0, 0, 0, 0, 1, 15, 1, 0);
    add(1, 200, 0, 0, 0, 0, 0, 1, 15, 2, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 127, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
    // Factor 8, shift 3: 8 x -2000 -> -2000 -> -128; 8 x 40 -> 40.
    add(0, 0, 1, 3, 3, 0, 0,   0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(1, -2000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, -2000, 0, 0, 0, 0, 0, 1, -128, 1, 0);
    for (int i = 0; i < 7; i++) add(1, 40, 0, 0, 0, 0, 0, 1, -128, 1, 0);
    add(1, 40, 0, 0, 0, 0, 0,  1, -128, 2, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 40, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
    // Arithmetic shift of a negative value: -30 >>> 2 = -8.
    add(0, 0, 1, 0, 2, 0, 0,   0, 0, 0, 0);
    add(1, -30, 0, 0, 0, 0, 0, 1, -8, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
    // Saturation edges at shift 0: 127, 128, -128, -129.
    add(0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0);
    add(1, 127, 0, 0, 0, 0, 0, 1, 127, 1, 0);
    add(1, 128, 0, 0, 0, 0, 0, 1, 127, 2, 0);
    add(1, -128, 0, 0, 0, 0, 0, 1, 127, 3, 0);
    add(1, -129, 0, 0, 0, 0, 0, 1, 127, 4, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 127, 3, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, -128, 2, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, -128, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
    // Overflow: 1..5 with no reads, drain, read when empty, clear.
    for (int i = 1; i <= 4; i++) add(1, i, 0, 0, 0, 0, 0, 1, 1, i, 0);
    add(1, 5, 0, 0, 0, 0, 0,   1, 1, 4, 1);
    add(0, 0, 0, 0, 0, 1, 0,   1, 2, 3, 1);
    add(0, 0, 0, 0, 0, 1, 0,   1, 3, 2, 1);
    add(0, 0, 0, 0, 0, 1, 0,   1, 4, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    // Full with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) add(1, i, 0, 0, 0, 0, 0, 1, 1, i, 0);
    add(1, 6, 0, 0, 0, 1, 0,   1, 2, 4, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 3, 3, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 4, 2, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 6, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
    // Push and pop together while empty: pop ignored.
    add(1, 9, 0, 0, 0, 1, 0,   1, 9, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
    // Drop and clr_ovf in the same cycle: set wins.
    for (int i = 1; i <= 4; i++) add(1, i, 0, 0, 0, 0, 0, 1, 1, i, 0);
    add(1, 5, 0, 0, 0, 0, 1,   1, 1, 4, 1);
    add(0, 0, 0, 0, 0, 0, 1,   1, 1, 4, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 2, 3, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 3, 2, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 4, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
    // cfg_load mid-frame discards partial 10; concurrent sample 99 dropped.
    add(0, 0, 1, 2, 0, 0, 0,   0, 0, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(1, 99, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    add(1, 7, 0, 0, 0, 0, 0,   1, 7, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);

    // Reset state.
    #2;
    chk_all("reset", -1, 1'b0, 8'd0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].cl, vecs[i].dc, vecs[i].sh, vecs[i].rd, vecs[i].co);
      chk_all("vec", i, vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].eo);
    end

    // Async reset with a full, overflowed FIFO and a partial factor-4 sum.
    for (int i = 1; i <= 5; i++) drive(1'b1, 16'(i), 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b1, 2'd2, 4'd2, 1'b0, 1'b0);
    drive(1'b1, 16'd50, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
    chk_all("pre_rst", -2, 1'b1, 8'd1, 3'd4, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", -3, 1'b0, 8'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 16'd33, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
    chk_all("post_rst", -4, 1'b1, 8'd33, 3'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
- Downstream stage of the FIR datapath. Consumes the 16-bit signed filtered sample stream.
- Performs accumulate-and-dump decimation by 1/2/4/8, then a programmable arithmetic right shift, then saturation to signed 8-bit.
- Buffers results in a small show-ahead FIFO so the pin-limited output side can read them at its own pace.
- Reports FIFO level and a sticky overflow flag for status readback.

Parameters:
- IN_W, 16, input sample width (signed)
- ACC_W, 19, accumulator width: IN_W plus 3 guard bits for a 8-sample sum
- OUT_W, 8, output sample width (signed, saturated)
- DEPTH, 4, FIFO entries (power of two, at least 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_data is a new filtered sample this cycle
- in_data  in  IN_W  filtered sample, two's complement
- cfg_load  in  1  one-cycle pulse: latch cfg_decim/cfg_shift, restart the decimation phase
- cfg_decim  in  2  decimation code: 00=1, 01=2, 10=4, 11=8
- cfg_shift  in  4  arithmetic right shift applied to the dump sum (0..15)
- out_rd  in  1  pop the FIFO head
- out_data  out  OUT_W  FIFO head (show-ahead); 0 when empty
- out_valid  out  1  FIFO not empty
- fifo_level  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- overflow  out  1  sticky: a result was dropped because the FIFO was full
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset (asynchronous, rst_n=0):
  - acc=0, phase=0; decim register=00, shift register=0.
  - FIFO empty: out_valid=0, out_data=0, fifo_level=0, overflow=0.
- Config:
  - Active configuration lives in registers and changes only on a cfg_load pulse.
  - cfg_load discards any partial sum: acc=0, phase=0.
  - If cfg_load and in_valid occur together, cfg_load wins and the sample is dropped.
  - The FIFO contents are not affected by cfg_load.
- Decimation (N = 1<<decim):
  - On each in_valid, sum = acc + sign-extended in_data, computed in ACC_W bits.
  - If phase == N-1: dump the sum, then acc=0 and phase=0.
  - Otherwise: acc=sum and phase=phase+1.
  - With N=1, every sample dumps.
  - No in_valid: state holds.
- Dump arithmetic:
  - scaled = sum >>> shift (arithmetic shift, sign preserved).
  - Saturate scaled to [-128, 127].
  - The saturated byte is pushed into the FIFO in the same cycle.
- Latency:
  - A dump on the in_valid at edge t makes the result visible on out_data/out_valid after edge t.
  - If the FIFO was empty, that result becomes the head.
- FIFO:
  - Registered pointers; out_data = mem[rd_ptr] when not empty, else 0.
  - out_rd while empty: ignored, no state change.
  - Push while full with no pop: the new result is dropped and overflow is set to 1.
  - Push and pop in the same cycle while full: both happen, level stays DEPTH, no overflow.
  - Push and pop in the same cycle while empty: the push happens and the pop is ignored (level becomes 1).
  - Pointers wrap modulo DEPTH.
- overflow:
  - Set on a dropped push; cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, set wins.
- Reset mid-operation:
  - Asynchronous return to the reset state, including mid-accumulation.
  - Partial sums and FIFO contents are lost.

Decomposition:
- Shared package fir_pkg holds:
  - widths IN_W/ACC_W/OUT_W;
  - decimation code constants DECIM_1/2/4/8;
  - saturation limits OUT_MAX=127 and OUT_MIN=-128.
- One sub-module, fir_sync_fifo: parameterised width/depth, show-ahead, with push/pop/full/empty/level outputs.
- Decimator and saturation logic stay in fir_decim_out.

Test Plan:
- Factor 2, shift 1: cfg_load decim=01 shift=1; samples 10, 20, 100, 200 → FIFO receives 15 then 127 (300>>>1=150, saturated); out_valid rises one cycle after the 2nd sample.
- Factor 8, shift 3: eight samples of -2000 → sum -16000 (fits ACC_W), >>>3 = -2000 → saturated to -128. Eight samples of 40 → 40.
- Overflow: factor 1, shift 0, samples 1..5 with no reads → fifo_level=4, overflow=1; reads return 1, 2, 3, 4; a read when empty keeps out_data=0 and level 0; clr_ovf clears overflow.
- Full with simultaneous push/pop: FIFO holding 1, 2, 3, 4; in_valid=6 with out_rd in the same cycle → level stays 4, overflow stays 0, head becomes 2, drain order 2, 3, 4, 6.
- cfg_load mid-frame: factor 4; samples 5, 5 then cfg_load (decim=00); then sample 7 → only 7 is pushed; the partial sum 10 never appears.
- Async reset mid-accumulation and with a non-empty FIFO: drop rst_n between clock edges → out_valid=0, out_data=0, level=0, overflow=0 immediately; after release, factor 1 is active.
